// File: rtl/regfile_onehot.sv
// 31 x 32-bit register file with a one-hot write select, two combinational read ports,
// optional write-to-read forwarding and a sticky multi-select error flag.
module regfile_onehot #(
  parameter bit BYPASS = 1'b1
) (
  input  logic        clock,
  input  logic        ctrl_reset,
  input  logic        ctrl_writeEnable,
  input  logic [31:0] ctrl_writeSel,
  input  logic [31:0] data_writeReg,
  input  logic [4:0]  ctrl_readRegA,
  input  logic [4:0]  ctrl_readRegB,
  output logic [31:0] data_readRegA,
  output logic [31:0] data_readRegB,
  output logic        err_multiSel
);

  // Register 0 is never stored; only indices 1..31 hold state.
  logic [31:0] r_regs [1:31];
  logic        r_err_multi;

  logic [31:1] w_sel_hi;
  logic        w_multi;
  logic [31:0] w_view [32];
  logic        w_byp_a;
  logic        w_byp_b;

  assign w_sel_hi = ctrl_writeSel[31:1];
  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign w_multi  = |(w_sel_hi & (w_sel_hi - 31'd1));

  // Register array: async clear, every selected register loads the write data.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      for (int i = 1; i < 32; i++) begin
        r_regs[i] <= '0;
      end
    end else if (ctrl_writeEnable) begin
      for (int i = 1; i < 32; i++) begin
        if (ctrl_writeSel[i]) begin
          r_regs[i] <= data_writeReg;
        end
      end
    end
  end

  // Sticky error flag, set by any qualified write touching two or more registers.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      r_err_multi <= 1'b0;
    end else if (ctrl_writeEnable && w_multi) begin
      r_err_multi <= 1'b1;
    end
  end

  // Full 32-entry read view with a hard-wired zero at index 0; gated to zero in reset.
  always_comb begin
    w_view[0] = '0;
    for (int i = 1; i < 32; i++) begin
      w_view[i] = ctrl_reset ? 32'h0 : r_regs[i];
    end
  end

  // Forwarding qualifiers: never for address 0 and never while reset is high.
  always_comb begin
    w_byp_a = BYPASS && !ctrl_reset && ctrl_writeEnable && (ctrl_readRegA != 5'd0) &&
              ctrl_writeSel[ctrl_readRegA];
    w_byp_b = BYPASS && !ctrl_reset && ctrl_writeEnable && (ctrl_readRegB != 5'd0) &&
              ctrl_writeSel[ctrl_readRegB];
  end

  // Read port muxes.
  always_comb begin
    data_readRegA = w_byp_a ? data_writeReg : w_view[ctrl_readRegA];
    data_readRegB = w_byp_b ? data_writeReg : w_view[ctrl_readRegB];
  end

  assign err_multiSel = r_err_multi;

endmodule
